// File: rtl/vga_vtim_meas.sv
// Measures sync/gate timing of an incoming video line and reports the
// vga_vtim programming values (N-1 encoded) with line-to-line lock detection.
module vga_vtim_meas #(
    parameter int LOCK_N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        sync,
    input  logic        gate,
    output logic [7:0]  Tsync,
    output logic [7:0]  Tgdel,
    output logic [15:0] Tgate,
    output logic [15:0] Tlen,
    output logic        valid,
    output logic        locked,
    output logic        err
);

    localparam int LW = $clog2(LOCK_N + 1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_N);
    localparam logic [16:0]   CNT8_MAX  = 17'h00100;
    localparam logic [16:0]   CNT16_MAX = 17'h10000;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        GDEL,
        GATE,
        TAIL
    } state_t;

    state_t state, state_nx;

    logic          sync_q, gate_q;
    logic          sync_rise, sync_fall, gate_rise, gate_fall;
    logic [16:0]   cnt, cnt_nx;
    logic [16:0]   plen, plen_nx;
    logic [7:0]    tsync_w, tsync_nx;
    logic [7:0]    tgdel_w, tgdel_nx;
    logic [15:0]   tgate_w, tgate_nx;
    logic [15:0]   tlen_c;
    logic          commit, fault;
    logic          same_vals;
    logic [LW-1:0] lock_cnt, lock_nx;

    always_comb begin
        sync_rise = sync & ~sync_q;
        sync_fall = ~sync & sync_q;
        gate_rise = gate & ~gate_q;
        gate_fall = ~gate & gate_q;
    end

    // Line tracker: per-phase counters, overflow checks and commit/fault decisions
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        plen_nx  = (state == IDLE) ? plen : plen + 17'd1;
        tsync_nx = tsync_w;
        tgdel_nx = tgdel_w;
        tgate_nx = tgate_w;
        commit   = 1'b0;
        fault    = 1'b0;

        case (state)
            IDLE: begin
                if (sync_rise) begin
                    state_nx = SYNC;
                    cnt_nx   = 17'd1;
                    plen_nx  = 17'd1;
                end
            end
            SYNC: begin
                if (gate) begin
                    fault = 1'b1;
                end else if (sync_fall) begin
                    tsync_nx = 8'(cnt - 17'd1);
                    cnt_nx   = 17'd1;
                    state_nx = GDEL;
                end else if (cnt == CNT8_MAX) begin
                    fault = 1'b1;
                end else begin
                    cnt_nx = cnt + 17'd1;
                end
            end
            GDEL: begin
                if (sync_rise) begin
                    fault = 1'b1;
                end else if (gate_rise) begin
                    tgdel_nx = 8'(cnt - 17'd1);
                    cnt_nx   = 17'd1;
                    state_nx = GATE;
                end else if (cnt == CNT8_MAX) begin
                    fault = 1'b1;
                end else begin
                    cnt_nx = cnt + 17'd1;
                end
            end
            GATE: begin
                // A gate fall landing on the next sync rise still closes a good line
                if (gate_fall) begin
                    tgate_nx = 16'(cnt - 17'd1);
                    if (sync_rise) begin
                        commit = 1'b1;
                    end else begin
                        state_nx = TAIL;
                    end
                end else if (sync_rise) begin
                    fault = 1'b1;
                end else if (cnt == CNT16_MAX) begin
                    fault = 1'b1;
                end else begin
                    cnt_nx = cnt + 17'd1;
                end
            end
            TAIL: begin
                if (sync_rise) begin
                    commit = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if ((state != IDLE) && !sync_rise && (plen == CNT16_MAX)) begin
            fault = 1'b1;
        end

        if (commit) begin
            state_nx = SYNC;
            cnt_nx   = 17'd1;
            plen_nx  = 17'd1;
        end

        // A faulting sync rise starts measuring the new line straight away
        if (fault) begin
            state_nx = sync_rise ? SYNC : IDLE;
            cnt_nx   = 17'd1;
            plen_nx  = 17'd1;
        end
    end

    always_comb begin
        tlen_c    = 16'(plen - 17'd1);
        same_vals = (lock_cnt != '0) &&
                    (tsync_w  == Tsync) && (tgdel_w == Tgdel) &&
                    (tgate_nx == Tgate) && (tlen_c  == Tlen);
        if (!same_vals) begin
            lock_nx = LW'(1);
        end else if (lock_cnt == LOCK_MAX) begin
            lock_nx = lock_cnt;
        end else begin
            lock_nx = lock_cnt + LW'(1);
        end
    end

    // valid/err are single-clock pulses even if ena drops right after the event
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sync_q   <= 1'b0;
            gate_q   <= 1'b0;
            cnt      <= '0;
            plen     <= '0;
            tsync_w  <= '0;
            tgdel_w  <= '0;
            tgate_w  <= '0;
            Tsync    <= '0;
            Tgdel    <= '0;
            Tgate    <= '0;
            Tlen     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (ena) begin
                sync_q  <= sync;
                gate_q  <= gate;
                state   <= state_nx;
                cnt     <= cnt_nx;
                plen    <= plen_nx;
                tsync_w <= tsync_nx;
                tgdel_w <= tgdel_nx;
                tgate_w <= tgate_nx;
                if (commit) begin
                    Tsync    <= tsync_w;
                    Tgdel    <= tgdel_w;
                    Tgate    <= tgate_nx;
                    Tlen     <= tlen_c;
                    valid    <= 1'b1;
                    lock_cnt <= lock_nx;
                    locked   <= (lock_nx >= LOCK_MAX);
                end
                if (fault) begin
                    err      <= 1'b1;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_vtim_meas.sv
// Scoreboard bench for vga_vtim_meas: lines are described by their timing and
// a line-level model predicts each valid/err pulse.
module tb_vga_vtim_meas;

    localparam int LOCK_N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        sync = 1'b0;
    logic        gate = 1'b0;
    logic [7:0]  Tsync, Tgdel;
    logic [15:0] Tgate, Tlen;
    logic        valid, locked, err;

    vga_vtim_meas #(.LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .ena(ena), .sync(sync), .gate(gate),
        .Tsync(Tsync), .Tgdel(Tgdel), .Tgate(Tgate), .Tlen(Tlen),
        .valid(valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef enum int {L_GOOD, L_ERR_GSYNC, L_ERR_GDEL, L_ERR_GATE, L_ERR_OVF} kind_t;
    typedef struct { kind_t kind; int s; int g; int w; int p; } line_t;
    typedef struct { bit is_err; int ts; int tg; int tgt; int tl; bit lk; } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    ena_mode = 0;
    bit    gate_carry = 1'b0;
    bit    have_prev = 1'b0;
    line_t prev_line;
    int    lock_cnt = 0;
    int    o_ts = 0, o_tg = 0, o_tgt = 0, o_tl = 0;

    function automatic void check(string name, longint act, longint req);
        checks++;
        if (act == req) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endfunction

    function automatic line_t mk(kind_t k, int s, int g, int w, int p);
        line_t l;
        l.kind = k; l.s = s; l.g = g; l.w = w; l.p = p;
        return l;
    endfunction

    // Good line: the generator values are the interval lengths minus one
    function automatic void model_commit(line_t l);
        bit same;
        same = (lock_cnt > 0) && (o_ts == l.s - 1) && (o_tg == l.g - 1) &&
               (o_tgt == l.w - 1) && (o_tl == l.p - 1);
        lock_cnt = same ? ((lock_cnt < LOCK_N) ? lock_cnt + 1 : lock_cnt) : 1;
        o_ts = l.s - 1; o_tg = l.g - 1; o_tgt = l.w - 1; o_tl = l.p - 1;
        exp_q.push_back('{1'b0, o_ts, o_tg, o_tgt, o_tl, lock_cnt >= LOCK_N});
    endfunction

    function automatic void model_err();
        lock_cnt = 0;
        exp_q.push_back('{1'b1, o_ts, o_tg, o_tgt, o_tl, 1'b0});
    endfunction

    // Every sync rise closes the previous line: good lines commit, lines broken
    // by this rise error; lines broken inside themselves error on their own.
    function automatic void model_rise(line_t l);
        if (have_prev) begin
            case (prev_line.kind)
                L_GOOD:                 model_commit(prev_line);
                L_ERR_GDEL, L_ERR_GATE: model_err();
                default: ;
            endcase
        end
        if (l.kind == L_ERR_GSYNC || l.kind == L_ERR_OVF) model_err();
        prev_line = l;
        have_prev = 1'b1;
    endfunction

    function automatic void wave(input line_t l, input int c, output bit sv, output bit gv);
        int gs;
        sv = (c < l.s);
        gv = 1'b0;
        case (l.kind)
            L_GOOD:      gv = (c >= l.s + l.g) && (c < l.s + l.g + l.w);
            L_ERR_GSYNC: begin
                gs = l.s - 1 + l.g;
                gv = (c >= gs) && (c < gs + l.w);
            end
            L_ERR_GATE:  gv = (c >= l.s + l.g);
            default:     gv = 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input bit sv, input bit gv);
        int pauses;
        pauses = (ena_mode == 1) ? 1 : (ena_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < pauses; i++) begin
            ena = 1'b0; sync = 1'($urandom); gate = 1'($urandom);
            @(posedge clk); #1;
        end
        ena = 1'b1; sync = sv; gate = gv;
        @(posedge clk); #1;
    endtask

    task automatic drive_line(input line_t l, input int abort_at);
        bit sv, gv;
        model_rise(l);
        for (int c = 0; c < l.p; c++) begin
            if (c == abort_at) return;
            wave(l, c, sv, gv);
            if (c == 0) begin
                gv = gv | gate_carry;
                gate_carry = 1'b0;
            end
            applyStimulus(sv, gv);
        end
        gate_carry = (l.kind == L_ERR_GATE);
    endtask

    task automatic checkOutput(input exp_t e);
        check("valid", valid, !e.is_err);
        check("err", err, e.is_err);
        check("Tsync", Tsync, e.ts);
        check("Tgdel", Tgdel, e.tg);
        check("Tgate", Tgate, e.tgt);
        check("Tlen", Tlen, e.tl);
        check("locked", locked, e.lk);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_Tsync"}, Tsync, 0);
        check({tag, "_Tgdel"}, Tgdel, 0);
        check({tag, "_Tgate"}, Tgate, 0);
        check({tag, "_Tlen"}, Tlen, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (valid || err)) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {valid, err}, 0);
            else checkOutput(exp_q.pop_front());
        end
    end

    line_t a_line, b_line, l;
    int    r, reps;

    initial begin
        a_line = mk(L_GOOD, 5, 6, 7, 30);
        b_line = mk(L_GOOD, 5, 6, 8, 30);

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // lock on a repeated line, break it with a wider gate, relock
        repeat (4) drive_line(a_line, -1);
        repeat (2) drive_line(b_line, -1);
        // sync rise while gate is high, then recovery
        drive_line(mk(L_ERR_GATE, 5, 6, 0, 15), -1);
        repeat (3) drive_line(a_line, -1);
        // overlong sync
        drive_line(mk(L_ERR_OVF, 300, 0, 0, 305), -1);
        repeat (3) drive_line(a_line, -1);
        // 8-bit boundary, gate-fall on sync-rise, gate during sync, rise in gap
        repeat (2) drive_line(mk(L_GOOD, 256, 1, 1, 260), -1);
        drive_line(mk(L_ERR_OVF, 257, 0, 0, 262), -1);
        repeat (3) drive_line(mk(L_GOOD, 3, 2, 4, 9), -1);
        drive_line(mk(L_ERR_GSYNC, 4, 1, 3, 10), -1);
        drive_line(mk(L_ERR_GSYNC, 4, 0, 3, 10), -1);
        drive_line(a_line, -1);
        drive_line(mk(L_ERR_GDEL, 3, 0, 0, 6), -1);
        repeat (2) drive_line(a_line, -1);

        // reset while the gate is high
        drive_line(a_line, 13);
        rst = 1'b1; ena = 1'b1; sync = 1'b0; gate = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midline_reset");
        check("queue_at_reset", exp_q.size(), 0);
        have_prev = 1'b0; lock_cnt = 0; gate_carry = 1'b0;
        o_ts = 0; o_tg = 0; o_tgt = 0; o_tl = 0;
        applyStimulus(1'b0, 1'b0);

        // ena toggling every cycle must not change the measured values
        ena_mode = 1;
        repeat (4) drive_line(a_line, -1);

        // randomized lines with random ena pauses
        ena_mode = 2;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                l = mk(L_GOOD, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 8), 0);
                l.p = l.s + l.g + l.w + $urandom_range(0, 4);
            end else if (r < 78) begin
                l = mk(L_ERR_GSYNC, $urandom_range(2, 6), $urandom_range(0, 1), $urandom_range(1, 4), 0);
                l.p = l.s - 1 + l.g + l.w + $urandom_range(1, 3);
            end else if (r < 86) begin
                l = mk(L_ERR_GDEL, $urandom_range(1, 6), 0, 0, 0);
                l.p = l.s + $urandom_range(1, 6);
            end else if (r < 95) begin
                l = mk(L_ERR_GATE, $urandom_range(1, 6), $urandom_range(1, 6), 0, 0);
                l.p = l.s + l.g + $urandom_range(1, 5);
            end else begin
                l = mk(L_ERR_OVF, 257 + $urandom_range(0, 10), 0, 0, 0);
                l.p = l.s + 3;
            end
            reps = (l.kind == L_GOOD) ? $urandom_range(1, 3) : 1;
            for (int k = 0; k < reps; k++) drive_line(l, -1);
            if (l.kind == L_ERR_GATE) drive_line(a_line, -1);
        end
        drive_line(a_line, -1);

        ena_mode = 0;
        repeat (10) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
